// File: rtl/mshr_file.sv
// Unified miss-status holding register file: merges secondary misses per line,
// issues one fill per entry and replays merged targets in allocation order.
module mshr_file #(
  parameter int NUM_ENTRIES = 4,
  parameter int NUM_TARGETS = 2,
  parameter int LINE_BYTES  = 16,
  parameter int ROB_IDX_W   = 5
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           alloc_valid_i,
  output logic                           alloc_ready_o,
  input  logic [31:0]                    alloc_addr_i,
  input  logic                           alloc_is_store_i,
  input  logic [31:0]                    alloc_data_i,
  input  logic [ROB_IDX_W-1:0]           alloc_rob_idx_i,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [31:0]                    mem_req_addr_o,
  output logic [$clog2(NUM_ENTRIES)-1:0] mem_req_id_o,
  input  logic                           mem_resp_valid_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] mem_resp_id_i,
  output logic                           wake_valid_o,
  input  logic                           wake_ready_i,
  output logic [31:0]                    wake_addr_o,
  output logic [31:0]                    wake_data_o,
  output logic                           wake_is_store_o,
  output logic [ROB_IDX_W-1:0]           wake_rob_idx_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int ID_W   = $clog2(NUM_ENTRIES);
  localparam int OFS_W  = $clog2(LINE_BYTES);
  localparam int LINE_W = 32 - OFS_W;
  localparam int CNT_W  = $clog2(NUM_TARGETS + 1);
  localparam int TIDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  typedef enum logic [1:0] {
    ENT_FREE  = 2'd0,
    ENT_PEND  = 2'd1,
    ENT_WAIT  = 2'd2,
    ENT_DRAIN = 2'd3
  } ent_state_e;

  typedef enum logic {
    DR_IDLE   = 1'b0,
    DR_ACTIVE = 1'b1
  } drain_state_e;

  ent_state_e             ent_state_r      [NUM_ENTRIES];
  logic [LINE_W-1:0]      ent_line_r       [NUM_ENTRIES];
  logic                   ent_squash_r     [NUM_ENTRIES];
  logic [CNT_W-1:0]       ent_cnt_r        [NUM_ENTRIES];
  ent_state_e             ent_state_nxt_s  [NUM_ENTRIES];
  logic [LINE_W-1:0]      ent_line_nxt_s   [NUM_ENTRIES];
  logic                   ent_squash_nxt_s [NUM_ENTRIES];
  logic [CNT_W-1:0]       ent_cnt_nxt_s    [NUM_ENTRIES];

  logic [31:0]            tgt_addr_r  [NUM_ENTRIES][NUM_TARGETS];
  logic [31:0]            tgt_data_r  [NUM_ENTRIES][NUM_TARGETS];
  logic                   tgt_store_r [NUM_ENTRIES][NUM_TARGETS];
  logic [ROB_IDX_W-1:0]   tgt_rob_r   [NUM_ENTRIES][NUM_TARGETS];

  drain_state_e           drain_state_r, drain_state_nxt_s;
  logic [ID_W-1:0]        drain_ptr_r, drain_ptr_nxt_s;
  logic [TIDX_W-1:0]      drain_tgt_r, drain_tgt_nxt_s;

  logic [LINE_W-1:0]      alloc_line_s;
  logic [NUM_ENTRIES-1:0] match_vec_s, free_vec_s, pend_vec_s, drain_vec_s;
  logic [ID_W-1:0]        match_idx_s, free_idx_s, pend_idx_s, drain_idx_s;
  logic                   match_any_s, free_any_s, pend_any_s, drain_any_s;
  logic                   alloc_ready_s, alloc_fire_s, merge_fire_s, new_fire_s;
  logic                   req_fire_s, wake_fire_s, last_tgt_s;
  logic [ID_W-1:0]        tgt_wi_s;
  logic [TIDX_W-1:0]      tgt_wt_s;
  logic [31:0]            tgt_wdata_s;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_ENTRIES-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      idx = vec[i] ? ID_W'(i) : idx;
    end
    return idx;
  endfunction

  assign alloc_line_s = alloc_addr_i[31:OFS_W];

  // Per-entry status vectors used by every lookup below.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match_vec_s[i] = (ent_state_r[i] != ENT_FREE) && (ent_line_r[i] == alloc_line_s);
      free_vec_s[i]  = (ent_state_r[i] == ENT_FREE);
      pend_vec_s[i]  = (ent_state_r[i] == ENT_PEND);
      drain_vec_s[i] = (ent_state_r[i] == ENT_DRAIN);
    end
  end

  assign match_any_s = |match_vec_s;
  assign free_any_s  = |free_vec_s;
  assign pend_any_s  = |pend_vec_s;
  assign drain_any_s = |drain_vec_s;
  assign match_idx_s = lowest_idx(match_vec_s);
  assign free_idx_s  = lowest_idx(free_vec_s);
  assign pend_idx_s  = lowest_idx(pend_vec_s);
  assign drain_idx_s = lowest_idx(drain_vec_s);

  // A live entry for the line stalls unless it can still absorb a target.
  always_comb begin
    if (flush_i) begin
      alloc_ready_s = 1'b0;
    end else if (match_any_s) begin
      alloc_ready_s = ((ent_state_r[match_idx_s] == ENT_PEND) ||
                       (ent_state_r[match_idx_s] == ENT_WAIT)) &&
                      !ent_squash_r[match_idx_s] &&
                      (ent_cnt_r[match_idx_s] < CNT_W'(NUM_TARGETS));
    end else begin
      alloc_ready_s = free_any_s;
    end
  end

  assign alloc_ready_o = alloc_ready_s;
  assign alloc_fire_s  = alloc_valid_i && alloc_ready_s;
  assign merge_fire_s  = alloc_fire_s && match_any_s;
  assign new_fire_s    = alloc_fire_s && !match_any_s;
  assign req_fire_s    = pend_any_s && mem_req_ready_i;
  assign wake_fire_s   = (drain_state_r == DR_ACTIVE) && wake_ready_i;
  assign last_tgt_s    = (CNT_W'(drain_tgt_r) + CNT_W'(1'b1)) == ent_cnt_r[drain_ptr_r];

  assign tgt_wi_s    = match_any_s ? match_idx_s : free_idx_s;
  assign tgt_wt_s    = match_any_s ? ent_cnt_r[match_idx_s][TIDX_W-1:0] : {TIDX_W{1'b0}};
  assign tgt_wdata_s = alloc_is_store_i ? alloc_data_i : 32'h0;

  // Entry lifecycle: allocation, request issue, fill return, replay and flush.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_state_nxt_s[i]  = ent_state_r[i];
      ent_line_nxt_s[i]   = ent_line_r[i];
      ent_squash_nxt_s[i] = ent_squash_r[i];
      ent_cnt_nxt_s[i]    = ent_cnt_r[i];
      case (ent_state_r[i])
        ENT_FREE: begin
          if (new_fire_s && (free_idx_s == ID_W'(i))) begin
            ent_state_nxt_s[i]  = ENT_PEND;
            ent_line_nxt_s[i]   = alloc_line_s;
            ent_squash_nxt_s[i] = 1'b0;
            ent_cnt_nxt_s[i]    = CNT_W'(1'b1);
          end else begin
            ent_state_nxt_s[i] = ENT_FREE;
          end
        end
        ENT_PEND: begin
          if (req_fire_s && (pend_idx_s == ID_W'(i))) begin
            ent_state_nxt_s[i]  = ENT_WAIT;
            ent_squash_nxt_s[i] = flush_i;
          end else if (flush_i) begin
            ent_state_nxt_s[i] = ENT_FREE;
          end else begin
            ent_state_nxt_s[i] = ENT_PEND;
          end
        end
        ENT_WAIT: begin
          if (mem_resp_valid_i && (mem_resp_id_i == ID_W'(i))) begin
            ent_state_nxt_s[i] = (ent_squash_r[i] || flush_i) ? ENT_FREE : ENT_DRAIN;
          end else if (flush_i) begin
            ent_squash_nxt_s[i] = 1'b1;
          end else begin
            ent_state_nxt_s[i] = ENT_WAIT;
          end
        end
        ENT_DRAIN: begin
          if (flush_i || (wake_fire_s && last_tgt_s && (drain_ptr_r == ID_W'(i)))) begin
            ent_state_nxt_s[i] = ENT_FREE;
          end else begin
            ent_state_nxt_s[i] = ENT_DRAIN;
          end
        end
        default: begin
          ent_state_nxt_s[i] = ENT_FREE;
        end
      endcase
      if (merge_fire_s && (match_idx_s == ID_W'(i))) begin
        ent_cnt_nxt_s[i] = ent_cnt_r[i] + CNT_W'(1'b1);
      end else begin
        ent_cnt_nxt_s[i] = ent_cnt_nxt_s[i];
      end
    end
  end

  // Entry state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_state_r[i]  <= ENT_FREE;
        ent_line_r[i]   <= {LINE_W{1'b0}};
        ent_squash_r[i] <= 1'b0;
        ent_cnt_r[i]    <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_state_r[i]  <= ent_state_nxt_s[i];
        ent_line_r[i]   <= ent_line_nxt_s[i];
        ent_squash_r[i] <= ent_squash_nxt_s[i];
        ent_cnt_r[i]    <= ent_cnt_nxt_s[i];
      end
    end
  end

  // Target storage: at most one target is captured per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        for (int t = 0; t < NUM_TARGETS; t++) begin
          tgt_addr_r[i][t]  <= 32'h0;
          tgt_data_r[i][t]  <= 32'h0;
          tgt_store_r[i][t] <= 1'b0;
          tgt_rob_r[i][t]   <= {ROB_IDX_W{1'b0}};
        end
      end
    end else if (alloc_fire_s) begin
      tgt_addr_r[tgt_wi_s][tgt_wt_s]  <= alloc_addr_i;
      tgt_data_r[tgt_wi_s][tgt_wt_s]  <= tgt_wdata_s;
      tgt_store_r[tgt_wi_s][tgt_wt_s] <= alloc_is_store_i;
      tgt_rob_r[tgt_wi_s][tgt_wt_s]   <= alloc_rob_idx_i;
    end else begin
      tgt_addr_r  <= tgt_addr_r;
      tgt_data_r  <= tgt_data_r;
      tgt_store_r <= tgt_store_r;
      tgt_rob_r   <= tgt_rob_r;
    end
  end

  // Drain engine state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_state_r <= DR_IDLE;
      drain_ptr_r   <= {ID_W{1'b0}};
      drain_tgt_r   <= {TIDX_W{1'b0}};
    end else begin
      drain_state_r <= drain_state_nxt_s;
      drain_ptr_r   <= drain_ptr_nxt_s;
      drain_tgt_r   <= drain_tgt_nxt_s;
    end
  end

  // Drain engine next state: lock one DRAIN entry and walk its targets.
  always_comb begin
    drain_state_nxt_s = drain_state_r;
    drain_ptr_nxt_s   = drain_ptr_r;
    drain_tgt_nxt_s   = drain_tgt_r;
    case (drain_state_r)
      DR_IDLE: begin
        if (!flush_i && drain_any_s) begin
          drain_state_nxt_s = DR_ACTIVE;
          drain_ptr_nxt_s   = drain_idx_s;
          drain_tgt_nxt_s   = {TIDX_W{1'b0}};
        end else begin
          drain_state_nxt_s = DR_IDLE;
        end
      end
      DR_ACTIVE: begin
        if (flush_i || (wake_fire_s && last_tgt_s)) begin
          drain_state_nxt_s = DR_IDLE;
        end else if (wake_fire_s) begin
          drain_tgt_nxt_s = drain_tgt_r + TIDX_W'(1'b1);
        end else begin
          drain_state_nxt_s = DR_ACTIVE;
        end
      end
      default: begin
        drain_state_nxt_s = DR_IDLE;
      end
    endcase
  end

  // Drain engine outputs: replay fields are zero whenever nothing is locked.
  always_comb begin
    wake_valid_o    = 1'b0;
    wake_addr_o     = 32'h0;
    wake_data_o     = 32'h0;
    wake_is_store_o = 1'b0;
    wake_rob_idx_o  = {ROB_IDX_W{1'b0}};
    case (drain_state_r)
      DR_ACTIVE: begin
        wake_valid_o    = 1'b1;
        wake_addr_o     = tgt_addr_r[drain_ptr_r][drain_tgt_r];
        wake_data_o     = tgt_data_r[drain_ptr_r][drain_tgt_r];
        wake_is_store_o = tgt_store_r[drain_ptr_r][drain_tgt_r];
        wake_rob_idx_o  = tgt_rob_r[drain_ptr_r][drain_tgt_r];
      end
      DR_IDLE: begin
        wake_valid_o = 1'b0;
      end
      default: begin
        wake_valid_o = 1'b0;
      end
    endcase
  end

  assign mem_req_valid_o = pend_any_s;
  assign mem_req_addr_o  = pend_any_s ? {ent_line_r[pend_idx_s], {OFS_W{1'b0}}} : 32'h0;
  assign mem_req_id_o    = pend_idx_s;
  assign full_o          = ~free_any_s;
  assign empty_o         = &free_vec_s;

endmodule

// File: tb/tb_mshr_file.sv
// Directed, table-driven bench for mshr_file with hand-written flush and reset sequences.
module tb_mshr_file;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        alloc_valid_i;
  logic        alloc_ready_o;
  logic [31:0] alloc_addr_i;
  logic        alloc_is_store_i;
  logic [31:0] alloc_data_i;
  logic [4:0]  alloc_rob_idx_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic [1:0]  mem_req_id_o;
  logic        mem_resp_valid_i;
  logic [1:0]  mem_resp_id_i;
  logic        wake_valid_o;
  logic        wake_ready_i;
  logic [31:0] wake_addr_o;
  logic [31:0] wake_data_o;
  logic        wake_is_store_o;
  logic [4:0]  wake_rob_idx_o;
  logic        full_o;
  logic        empty_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mshr_file #(.NUM_ENTRIES(4), .NUM_TARGETS(2), .LINE_BYTES(16), .ROB_IDX_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_addr_i(alloc_addr_i), .alloc_is_store_i(alloc_is_store_i),
    .alloc_data_i(alloc_data_i), .alloc_rob_idx_i(alloc_rob_idx_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_id_o(mem_req_id_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_id_i(mem_resp_id_i),
    .wake_valid_o(wake_valid_o), .wake_ready_i(wake_ready_i),
    .wake_addr_o(wake_addr_o), .wake_data_o(wake_data_o),
    .wake_is_store_o(wake_is_store_o), .wake_rob_idx_o(wake_rob_idx_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  typedef struct {
    logic        fl, av, st, mrr, rv, wr;
    logic [31:0] addr, data;
    logic [4:0]  rob;
    logic [1:0]  rid;
    logic        e_ar, e_rqv, e_wv, e_ws, e_full, e_empty;
    logic [31:0] e_rqa, e_wa, e_wd;
    logic [1:0]  e_rqi;
    logic [4:0]  e_wrob;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input int fl, av, addr, st, data, rob, mrr, rv, rid, wr,
                               input int ar, rqv, rqa, rqi, wv, wa, wd, ws, wrob, full, empty);
    vec_t v;
    v.fl = fl[0]; v.av = av[0]; v.addr = addr; v.st = st[0]; v.data = data; v.rob = rob[4:0];
    v.mrr = mrr[0]; v.rv = rv[0]; v.rid = rid[1:0]; v.wr = wr[0];
    v.e_ar = ar[0]; v.e_rqv = rqv[0]; v.e_rqa = rqa; v.e_rqi = rqi[1:0];
    v.e_wv = wv[0]; v.e_wa = wa; v.e_wd = wd; v.e_ws = ws[0]; v.e_wrob = wrob[4:0];
    v.e_full = full[0]; v.e_empty = empty[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input int fl, av, addr, st, data, rob, mrr, rv, rid, wr);
    @(negedge clk_i);
    flush_i          = fl[0];
    alloc_valid_i    = av[0];
    alloc_addr_i     = addr;
    alloc_is_store_i = st[0];
    alloc_data_i     = data;
    alloc_rob_idx_i  = rob[4:0];
    mem_req_ready_i  = mrr[0];
    mem_resp_valid_i = rv[0];
    mem_resp_id_i    = rid[1:0];
    wake_ready_i     = wr[0];
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},   32'(alloc_ready_o),   32'd1);
    chk({tag, "_reqv"},    32'(mem_req_valid_o), 32'd0);
    chk({tag, "_reqaddr"}, mem_req_addr_o,       32'd0);
    chk({tag, "_reqid"},   32'(mem_req_id_o),    32'd0);
    chk({tag, "_wakev"},   32'(wake_valid_o),    32'd0);
    chk({tag, "_wakeaddr"}, wake_addr_o,         32'd0);
    chk({tag, "_wakedata"}, wake_data_o,         32'd0);
    chk({tag, "_wakest"},  32'(wake_is_store_o), 32'd0);
    chk({tag, "_wakerob"}, 32'(wake_rob_idx_o),  32'd0);
    chk({tag, "_full"},    32'(full_o),          32'd0);
    chk({tag, "_empty"},   32'(empty_o),         32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0; alloc_valid_i = 1'b0; alloc_addr_i = 32'h0; alloc_is_store_i = 1'b0;
    alloc_data_i = 32'h0; alloc_rob_idx_i = 5'd0; mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0; mem_resp_id_i = 2'd0; wake_ready_i = 1'b1;

    // fl av addr st data rob | mrr rv rid wr || ar rqv rqa rqi | wv wa wd ws wrob | full empty
    // merge two misses to line 0x1000, stall the third, replay in order
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 1,0,0,0,       0,0,0,0,0,            0,1));
    vecs.push_back(mkv(0,1,'h1004,0,0,3,    0,0,0,1, 1,0,0,0,       0,0,0,0,0,            0,1));
    vecs.push_back(mkv(0,1,'h1008,1,'hDEAD,4, 0,0,0,1, 1,1,'h1000,0, 0,0,0,0,0,           0,0));
    vecs.push_back(mkv(0,1,'h100C,0,0,5,    1,0,0,1, 0,1,'h1000,0,  0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h100C,0,0,5,    1,0,0,1, 0,0,0,0,       0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h100C,0,0,5,    0,1,0,1, 0,0,0,0,       0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h100C,0,0,5,    0,0,0,1, 0,0,0,0,       0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h100C,0,0,5,    0,0,0,1, 0,0,0,0,       1,'h1004,0,0,3,       0,0));
    vecs.push_back(mkv(0,1,'h100C,0,0,5,    0,0,0,1, 0,0,0,0,       1,'h1008,'hDEAD,1,4,  0,0));
    vecs.push_back(mkv(0,1,'h100C,0,0,5,    0,0,0,1, 1,0,0,0,       0,0,0,0,0,            0,1));
    // fill all four entries, hold the request under backpressure
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 1,1,'h1000,0,  0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h2000,0,0,6,    0,0,0,1, 1,1,'h1000,0,  0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h3000,0,0,7,    0,0,0,1, 1,1,'h1000,0,  0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h4000,0,0,8,    0,0,0,1, 1,1,'h1000,0,  0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h5000,0,0,9,    0,0,0,1, 0,1,'h1000,0,  0,0,0,0,0,            1,0));
    vecs.push_back(mkv(0,1,'h5000,0,0,9,    0,0,0,1, 0,1,'h1000,0,  0,0,0,0,0,            1,0));
    vecs.push_back(mkv(0,1,'h5000,0,0,9,    1,0,0,1, 0,1,'h1000,0,  0,0,0,0,0,            1,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         1,0,0,1, 0,1,'h2000,1,  0,0,0,0,0,            1,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         1,0,0,1, 0,1,'h3000,2,  0,0,0,0,0,            1,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         1,0,0,1, 0,1,'h4000,3,  0,0,0,0,0,            1,0));
    // replay backpressure while a second entry enters DRAIN
    vecs.push_back(mkv(0,0,0,0,0,0,         0,1,2,1, 0,0,0,0,       0,0,0,0,0,            1,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,1,1,0, 0,0,0,0,       0,0,0,0,0,            1,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,0, 0,0,0,0,       1,'h3000,0,0,7,       1,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,0, 0,0,0,0,       1,'h3000,0,0,7,       1,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 0,0,0,0,       1,'h3000,0,0,7,       1,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 1,0,0,0,       0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 1,0,0,0,       1,'h2000,0,0,6,       0,0));
    // flush: entry 0/3 WAIT get squashed, entry 1 PEND is dropped
    vecs.push_back(mkv(0,1,'h6000,0,0,10,   0,0,0,1, 1,0,0,0,       0,0,0,0,0,            0,0));
    vecs.push_back(mkv(1,0,0,0,0,0,         0,0,0,1, 0,1,'h6000,1,  0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h1000,0,0,0,    1,0,0,1, 0,0,0,0,       0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h1000,0,0,0,    0,1,0,1, 0,0,0,0,       0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,0,'h1000,0,0,0,    0,1,3,1, 1,0,0,0,       0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 1,0,0,0,       0,0,0,0,0,            0,1));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 1,0,0,0,       0,0,0,0,0,            0,1));
    // merge in the same cycle as the fill response
    vecs.push_back(mkv(0,1,'h7004,0,0,11,   1,0,0,1, 1,0,0,0,       0,0,0,0,0,            0,1));
    vecs.push_back(mkv(0,0,0,0,0,0,         1,0,0,1, 1,1,'h7000,0,  0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,1,'h7008,1,'h1234,12, 0,1,0,1, 1,0,0,0,    0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 1,0,0,0,       0,0,0,0,0,            0,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 1,0,0,0,       1,'h7004,0,0,11,      0,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 1,0,0,0,       1,'h7008,'h1234,1,12, 0,0));
    vecs.push_back(mkv(0,0,0,0,0,0,         0,0,0,1, 1,0,0,0,       0,0,0,0,0,            0,1));

    drive(0,0,0,0,0,0, 0,0,0,1);
    chk_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.fl, v.av, v.addr, v.st, v.data, v.rob, v.mrr, v.rv, v.rid, v.wr);
      chk($sformatf("v%0d_ready", i), 32'(alloc_ready_o),   32'(v.e_ar));
      chk($sformatf("v%0d_reqv", i),  32'(mem_req_valid_o), 32'(v.e_rqv));
      chk($sformatf("v%0d_wakev", i), 32'(wake_valid_o),    32'(v.e_wv));
      chk($sformatf("v%0d_full", i),  32'(full_o),          32'(v.e_full));
      chk($sformatf("v%0d_empty", i), 32'(empty_o),         32'(v.e_empty));
      if (v.e_rqv) begin
        chk($sformatf("v%0d_reqaddr", i), mem_req_addr_o,     v.e_rqa);
        chk($sformatf("v%0d_reqid", i),   32'(mem_req_id_o),  32'(v.e_rqi));
      end
      if (v.e_wv) begin
        chk($sformatf("v%0d_wakeaddr", i), wake_addr_o,          v.e_wa);
        chk($sformatf("v%0d_wakedata", i), wake_data_o,          v.e_wd);
        chk($sformatf("v%0d_wakest", i),   32'(wake_is_store_o), 32'(v.e_ws));
        chk($sformatf("v%0d_wakerob", i),  32'(wake_rob_idx_o),  32'(v.e_wrob));
      end
    end

    // Flush cycle with a request handshake for a PEND entry and a response for a WAIT entry
    drive(0,1,'h8000,0,0,1, 0,0,0,1);
    drive(0,1,'h9000,0,0,2, 0,0,0,1);
    chk("fh_req0_id", 32'(mem_req_id_o), 32'd0);
    drive(0,0,0,0,0,0, 1,0,0,1);
    chk("fh_req0_valid", 32'(mem_req_valid_o), 32'd1);
    drive(1,0,0,0,0,0, 1,1,0,1);
    chk("fh_flush_ready", 32'(alloc_ready_o), 32'd0);
    chk("fh_flush_reqv", 32'(mem_req_valid_o), 32'd1);
    chk("fh_flush_reqaddr", mem_req_addr_o, 32'h9000);
    chk("fh_flush_reqid", 32'(mem_req_id_o), 32'd1);
    drive(0,1,'h9000,0,0,3, 1,0,0,1);
    chk("fh_squashed_ready", 32'(alloc_ready_o), 32'd0);
    chk("fh_after_reqv", 32'(mem_req_valid_o), 32'd0);
    chk("fh_after_empty", 32'(empty_o), 32'd0);
    drive(0,0,0,0,0,0, 0,1,1,1);
    chk("fh_resp_wakev", 32'(wake_valid_o), 32'd0);
    drive(0,0,0,0,0,0, 0,0,0,1);
    chk("fh_final_empty", 32'(empty_o), 32'd1);
    chk("fh_final_wakev", 32'(wake_valid_o), 32'd0);
    drive(0,0,0,0,0,0, 0,0,0,1);
    chk("fh_late_wakev", 32'(wake_valid_o), 32'd0);

    // Asynchronous reset with three entries in flight
    drive(0,1,'hA000,0,0,1, 0,0,0,1);
    drive(0,1,'hB000,0,0,2, 1,0,0,1);
    drive(0,1,'hC000,0,0,3, 0,0,0,1);
    chk("rm_busy_empty", 32'(empty_o), 32'd0);
    chk("rm_busy_reqid", 32'(mem_req_id_o), 32'd1);
    drive(0,0,0,0,0,0, 0,0,0,1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("rm");
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0,0,0,0,0,0, 0,0,0,1);
    chk("rm_post_reqv", 32'(mem_req_valid_o), 32'd0);
    chk("rm_post_empty", 32'(empty_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
